alu: RTL and testbench

// - 32-bit integer ALU for the R4 RV32I-style core's execute stage.
// - Performs add/sub, logic, shift and set-less-than ops on two 32-bit operands.
// - Returns a result plus negative and zero flags for branch and compare logic.
// - Outputs are registered: one clock of latency; one clock; sync active-low reset.
//

---
 rtl/alu.sv | 67 ++++++
 tb/tb_alu.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Execute-stage integer ALU: one registered result per clock, plus negative/zero flags.
// Synchronous active-low reset clears the result and reports zero.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  logic [SHW-1:0]   shamt;
  logic             lt_s, lt_u;
  logic [WIDTH-1:0] res_d;

  // Only the low bits of in2 select the shift distance; the rest are ignored.
  assign shamt = in2[SHW-1:0];
  assign lt_s  = $signed(in1) < $signed(in2);
  assign lt_u  = in1 < in2;

  always_comb begin
    res_d = '0;
    case (op)
      OP_ADD:  res_d = in1 + in2;
      OP_SUB:  res_d = in1 - in2;
      OP_SLL:  res_d = in1 << shamt;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, lt_u};
      OP_XOR:  res_d = in1 ^ in2;
      OP_SRL:  res_d = in1 >> shamt;
      OP_SRA:  res_d = $unsigned($signed(in1) >>> shamt);
      OP_OR:   res_d = in1 | in2;
      OP_AND:  res_d = in1 & in2;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      negative <= 1'b0;
      zero     <= 1'b1;
    end else begin
      result   <= res_d;
      negative <= res_d[WIDTH-1];
      zero     <= (res_d == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: arithmetic reference model checked every cycle, plus directed literal vectors.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2;
  logic [3:0]  op;
  logic [31:0] result;
  logic        negative, zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res;
  logic        exp_vld = 1'b0;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .op(op),
    .result(result), .negative(negative), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; shifts as multiply / floor-divide by 2**n.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    p  = 64'sd1 << sh;
    case (o)
      4'd0: r = ua + ub;
      4'd1: r = ua - ub;
      4'd2: r = ua * p;
      4'd3: r = (sa < sb) ? 1 : 0;
      4'd4: r = (ua < ub) ? 1 : 0;
      4'd5: r = longint'(a ^ b);
      4'd6: r = ua / p;
      4'd7: r = (sa >= 0) ? sa / p : -(((-sa) + p - 1) / p);
      4'd8: r = longint'(a | b);
      4'd9: r = longint'(a & b);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Model tracks what the DUT must have registered at each rising edge.
  always @(posedge clk) begin
    exp_res = (!rst_n) ? 32'd0 : model(op, in1, in2);
    exp_vld = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("cyc_result", result, exp_res);
      chk("cyc_negative", {31'd0, negative}, {31'd0, exp_res[31]});
      chk("cyc_zero", {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    end
  end

  task automatic vec(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic en, input logic ez);
    @(negedge clk);
    op = o; in1 = a; in2 = b;
    chk({name, "_model"}, model(o, a, b), er);
    @(posedge clk);
    #1;
    chk({name, "_res"}, result, er);
    chk({name, "_neg"}, {31'd0, negative}, {31'd0, en});
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    rst_n = 1'b0; op = 4'd0; in1 = 32'h1234_5678; in2 = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res", result, 32'd0);
    chk("reset_neg", {31'd0, negative}, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    vec("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1);
    vec("add",      4'd0, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0);
    vec("sub_neg",  4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
    vec("sub_eq",   4'd1, 32'h00000110, 32'h00000110, 32'h00000000, 1'b0, 1'b1);
    vec("and",      4'd9, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0);
    vec("or",       4'd8, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b1, 1'b0);
    vec("xor",      4'd5, 32'h0000000C, 32'h0000000A, 32'h00000006, 1'b0, 1'b0);
    vec("sll",      4'd2, 32'h0000000F, 32'h00000004, 32'h000000F0, 1'b0, 1'b0);
    vec("srl",      4'd6, 32'h000000F0, 32'h00000004, 32'h0000000F, 1'b0, 1'b0);
    vec("sra_pos",  4'd7, 32'h00000010, 32'h00000002, 32'h00000004, 1'b0, 1'b0);
    vec("sra_neg",  4'd7, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
    vec("sra_fill", 4'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b1, 1'b0);
    vec("sll_hi",   4'd2, 32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1'b0, 1'b0);
    vec("srl_zero", 4'd6, 32'h80000001, 32'h00000020, 32'h80000001, 1'b1, 1'b0);
    vec("slt_nn",   4'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    vec("slt_np",   4'd3, 32'hFFFFFFFF, 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    vec("slt_pn",   4'd3, 32'h000000FF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    vec("slt_eq",   4'd3, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
    vec("sltu_lt",  4'd4, 32'h000000FF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    vec("sltu_gt",  4'd4, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b1);
    vec("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
    vec("op_1010",  4'd10, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b0, 1'b1);
    vec("op_1111",  4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);

    // Back-to-back stream; every cycle is checked against the model.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      op  = 4'($urandom_range(0, 15));
      in1 = $urandom;
      in2 = (i % 4 == 0) ? in1 : $urandom;
      if (i % 7 == 0) in1 = 32'h80000000 | in1;
    end

    // Reset mid-stream discards the in-flight op.
    @(negedge clk);
    op = 4'd0; in1 = 32'h00000005; in2 = 32'h00000007; rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_res", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd1);
    chk("midrst_neg", {31'd0, negative}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post_rst", 4'd0, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
